centronix_rx_fifo: RTL and testbench
====================================

Name: centronix_rx_fifo

Overview:
- Clocked receive front-end for the Centronics printer input on the Scorpion card.
- Synchronises STROBE and captures each byte from the host into a small FIFO.
- Generates BUSY and ACK toward the host.
- Presents buffered bytes to the downstream SPI shift stage through a pop handshake, so the MCU can drain several bytes per SPI transaction instead of one byte per strobe.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- AW, 4: address width, equal to log2(DEPTH).
- BUSY_MIN, 8: minimum clk cycles BUSY is held after a captured strobe; range 1..255.
- ACK_LEN, 4: ACK pulse width in clk cycles; range 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- centronix  in  8  printer data bus, asynchronous to clk
- strobe  in  1  printer strobe, asynchronous to clk
- inv_strobe  in  1  1 = active strobe edge is the falling pin edge; 0 = rising pin edge
- inv_busy  in  1  BUSY output polarity invert
- busy  out  1  BUSY to host, XOR inv_busy
- ack  out  1  ACK to host, active-low pulse
- pop  in  1  consumer takes the head byte this cycle
- dout  out  8  head-of-FIFO byte, valid while empty=0
- empty  out  1  FIFO empty
- count  out  AW+1  number of bytes held, 0..DEPTH
- overrun  out  1  sticky: a byte was lost because the FIFO was full
- clr_ovr  in  1  clears overrun

Behaviour:
Reset (rst=0, asynchronous):
- FIFO empty, count=0, dout=0.
- overrun=0, internal busy=0 (pin = inv_busy), ack=1, FSM in IDLE.
- All synchroniser flops = 0.
- Reset asserted mid-operation discards FIFO contents and aborts any BUSY/ACK sequence immediately.

Input synchronisation and capture:
- Effective strobe s = strobe XOR inv_strobe, passed through a 2-flop synchroniser, then one history flop.
- Active edge = synchronised s 0->1. It yields a one-cycle push_evt.
- centronix is registered through the same 2-flop path.
- The byte written is the synchronised data in the push_evt cycle, i.e. data sampled 2 clk after the pin edge. Host data is stable across the strobe pulse by protocol.

FIFO:
- Circular buffer with AW-bit read/write pointers and a separate count register.
- Pointers wrap DEPTH-1 -> 0.
- push_evt with count<DEPTH: write, wptr+1, count+1.
- push_evt with count=DEPTH: byte dropped, overrun<=1, count unchanged.
- pop with empty=1: ignored, no pointer or count change.
- push_evt and pop in the same cycle, count>0 and count<DEPTH: both occur, count unchanged.
- push_evt and pop in the same cycle, count=DEPTH: pop frees one slot and the push is accepted, count unchanged, no overrun.
- push_evt and pop in the same cycle, count=0: the push is written, the pop is ignored, count becomes 1.
- dout is registered from the FIFO memory. It shows the new head the cycle after a pop, and the first byte the cycle after a push into an empty FIFO. empty deasserts in that same cycle.
- overrun clears on clr_ovr=1. If set and clear occur in the same cycle, set wins.

Handshake FSM (internal busy b; busy pin = b XOR inv_busy):
- IDLE: b=0, ack=1. push_evt -> HOLD, with b=1 in the same clock edge and timer loaded with BUSY_MIN-1.
- HOLD: b=1. Timer decrements each cycle; at 0 -> ACK, timer loaded with ACK_LEN-1.
- ACK: b=1, ack=0. At timer 0: go to FULL_WAIT if count=DEPTH, else IDLE with b=0 and ack=1.
- FULL_WAIT: b=1, ack=1. Leave to IDLE when count<DEPTH.
- push_evt while not in IDLE (host protocol violation): byte still handled per the FIFO rules; FSM state and timer unaffected.
- A push_evt that arrives in IDLE while count=DEPTH still starts HOLD; the byte is dropped and overrun set.
- inv_strobe/inv_busy changes take effect on the next clk. A change of inv_strobe may generate one spurious push_evt; the MCU changes it only while the FIFO is idle.

Latency:
- Strobe pin edge to busy pin change: 3 clk.
- Busy to ack fall: BUSY_MIN clk.

Test Plan:
- Reset, then one strobe pulse (inv_strobe=0, inv_busy=0) with data 0xA5 -> busy=1 3 clk after the edge; ack=0 for exactly 4 clk starting 8 clk after busy rises; busy=0 when ack returns high; empty=0, count=1, dout=0xA5.
- Five strobes with data 0x01..0x05, then pop each cycle -> dout sequence 0x01..0x05, then empty=1, count=0; a sixth pop is ignored and count stays 0.
- Seventeen strobes with no pops (DEPTH=16) -> count=16, 17th byte dropped, overrun=1, busy held in FULL_WAIT; one pop -> count=15, busy=0 next cycle; clr_ovr -> overrun=0.
- FIFO at count=16 with push_evt and pop in the same cycle -> count stays 16, overrun stays 0, tail byte is the new data.
- inv_strobe=1, inv_busy=1, falling strobe edge with data 0x3C -> captured as 0x3C; busy pin idle 1, asserted 0.
- Assert rst mid-HOLD with count=3 -> immediately count=0, empty=1, ack=1, busy pin = inv_busy, overrun=0.

Source files
------------

// File: rtl/centronix_rx_fifo.sv
// Centronics receive front-end: synchronises STROBE/data, buffers bytes in a
// small FIFO, and runs the BUSY/ACK handshake toward the host.
module centronix_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int BUSY_MIN = 8,
  parameter int ACK_LEN  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    centronix,
  input  logic          strobe,
  input  logic          inv_strobe,
  input  logic          inv_busy,
  output logic          busy,
  output logic          ack,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overrun,
  input  logic          clr_ovr,
  output logic [1:0]    state_dbg
);

  // Consumer handshake: dout is valid while empty=0; a byte transfers on any
  // cycle with pop=1 and empty=0. pop while empty is ignored.

  typedef enum logic [1:0] {IDLE, HOLD, ACK_ST, FULL_WAIT} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic          s_meta, s_sync, s_hist;
  logic [7:0]    d_meta, d_sync;
  logic          push_evt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_inc;
  logic          full, do_push, do_pop, drop;
  state_t        state, state_nxt;
  logic [7:0]    timer, timer_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
      s_hist <= 1'b0;
      d_meta <= 8'h00;
      d_sync <= 8'h00;
    end else begin
      s_meta <= strobe ^ inv_strobe;
      s_sync <= s_meta;
      s_hist <= s_sync;
      d_meta <= centronix;
      d_sync <= d_meta;
    end
  end

  assign push_evt = s_sync & ~s_hist;
  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign do_pop   = pop & ~empty;
  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_push  = push_evt & (~full | do_pop);
  assign drop     = push_evt & full & ~do_pop;
  assign rptr_inc = rptr + AW'(1);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= d_sync;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      dout    <= 8'h00;
      overrun <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr_inc;
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
      // dout is the registered head; the byte being written bypasses memory
      // when it becomes the new head in the same cycle.
      if (do_pop) begin
        if (count > ONE_C)  dout <= mem[rptr_inc];
        else if (do_push)   dout <= d_sync;
      end else if (do_push && empty) begin
        dout <= d_sync;
      end
      if (drop)         overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      timer <= 8'h00;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        if (push_evt) begin
          state_nxt = HOLD;
          timer_nxt = 8'(BUSY_MIN - 1);
        end
      end
      HOLD: begin
        if (timer == 8'h00) begin
          state_nxt = ACK_ST;
          timer_nxt = 8'(ACK_LEN - 1);
        end else begin
          timer_nxt = timer - 8'h01;
        end
      end
      ACK_ST: begin
        if (timer == 8'h00) state_nxt = full ? FULL_WAIT : IDLE;
        else                timer_nxt = timer - 8'h01;
      end
      FULL_WAIT: begin
        if (!full) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE) ^ inv_busy;
  assign ack       = (state != ACK_ST);
  assign state_dbg = state;

endmodule

// File: tb/tb_centronix_rx_fifo.sv
// Self-checking bench for centronix_rx_fifo: directed scenarios plus a random
// run scored against a queue-based FIFO and timeline-based handshake model.
module tb_centronix_rx_fifo;
  localparam int DEPTH = 16, AW = 4, BUSY_MIN = 8, ACK_LEN = 4;

  logic          clk = 1'b0, rst = 1'b0;
  logic [7:0]    centronix = 8'h00;
  logic          strobe = 1'b0, inv_strobe = 1'b0, inv_busy = 1'b0;
  logic          pop = 1'b0, clr_ovr = 1'b0;
  logic          busy, ack, empty, overrun;
  logic [7:0]    dout;
  logic [AW:0]   count;
  logic [1:0]    state_dbg;

  centronix_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .BUSY_MIN(BUSY_MIN), .ACK_LEN(ACK_LEN)) dut (
    .clk(clk), .rst(rst), .centronix(centronix), .strobe(strobe),
    .inv_strobe(inv_strobe), .inv_busy(inv_busy), .busy(busy), .ack(ack),
    .pop(pop), .dout(dout), .empty(empty), .count(count), .overrun(overrun),
    .clr_ovr(clr_ovr), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;

  // Reference model: byte queue, sticky overrun, handshake as a timeline.
  logic [7:0] exp_q[$];
  bit         m_ov, hs_act, fw;
  int         hs_start;
  bit         push_at[int];
  logic [7:0] data_at[int];

  function automatic bit m_busy();
    return hs_act || fw;
  endfunction

  function automatic bit m_ack();
    return !(hs_act && (cyc - hs_start) >= BUSY_MIN);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ov = 0; hs_act = 0; fw = 0;
    push_at.delete();
    data_at.delete();
  endtask

  task automatic tick();
    bit push, set_ov;
    int cnt_pre;
    @(posedge clk);
    cyc++;
    if (rst) begin
      cnt_pre = exp_q.size();
      push = push_at.exists(cyc);
      if (hs_act) begin
        if (cyc - hs_start == BUSY_MIN + ACK_LEN) begin
          hs_act = 0;
          fw = (cnt_pre == DEPTH);
        end
      end else if (fw) begin
        if (cnt_pre < DEPTH) fw = 0;
      end else if (push) begin
        hs_act = 1;
        hs_start = cyc;
      end
      if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      set_ov = 0;
      if (push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(data_at[cyc]);
        else set_ov = 1;
      end
      if (set_ov) m_ov = 1;
      else if (clr_ovr) m_ov = 0;
    end
    #1;
  endtask

  // The byte on the bus now is the one captured three edges later.
  task automatic drive_strobe(input logic st, input logic inv, input logic [7:0] d);
    logic old_eff, new_eff;
    old_eff = strobe ^ inv_strobe;
    new_eff = st ^ inv;
    strobe = st;
    inv_strobe = inv;
    centronix = d;
    if (!old_eff && new_eff) begin
      push_at[cyc+3] = 1;
      data_at[cyc+3] = d;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    drive_strobe(~inv_strobe, inv_strobe, d);
    tick(); tick();
    drive_strobe(inv_strobe, inv_strobe, d);
    repeat (14) tick();
  endtask

  task automatic drain();
    pop = 1;
    repeat (DEPTH + 2) tick();
    pop = 0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (count !== 0)        begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1)     begin failures++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (dout !== 8'h00)     begin failures++; $display("FAIL reset_dout: got %h expected 00", dout); end
    checks++; if (overrun !== 1'b0)   begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (ack !== 1'b1)       begin failures++; $display("FAIL reset_ack: got %b expected 1", ack); end
    checks++; if (busy !== inv_busy)  begin failures++; $display("FAIL reset_busy: got %b expected %b", busy, inv_busy); end
    rst = 1;
    repeat (2) tick();
    checks++; if (count !== 0 || busy !== 1'b0) begin failures++; $display("FAIL reset_release: count %0d busy %b expected 0 0", count, busy); end
  endtask

  task automatic test_single_strobe();
    int c0, rise, afall, arise, boff;
    rise = -1; afall = -1; arise = -1; boff = -1;
    c0 = cyc;
    drive_strobe(1'b1, 1'b0, 8'hA5);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 1) drive_strobe(1'b0, 1'b0, 8'hA5);
      checks++; if (busy !== (m_busy() ^ inv_busy)) begin failures++; $display("FAIL single_busy cyc %0d: got %b expected %b", cyc, busy, m_busy() ^ inv_busy); end
      checks++; if (ack !== m_ack()) begin failures++; $display("FAIL single_ack cyc %0d: got %b expected %b", cyc, ack, m_ack()); end
      if (busy && rise < 0) rise = cyc;
      if (!ack && afall < 0) afall = cyc;
      if (afall >= 0 && ack && arise < 0) arise = cyc;
      if (rise >= 0 && !busy && boff < 0) boff = cyc;
    end
    checks++; if (rise != c0 + 3)            begin failures++; $display("FAIL single_busy_latency: got %0d expected %0d", rise - c0, 3); end
    checks++; if (afall != rise + BUSY_MIN)  begin failures++; $display("FAIL single_ack_delay: got %0d expected %0d", afall - rise, BUSY_MIN); end
    checks++; if (arise - afall != ACK_LEN)  begin failures++; $display("FAIL single_ack_width: got %0d expected %0d", arise - afall, ACK_LEN); end
    checks++; if (boff != arise)             begin failures++; $display("FAIL single_busy_release: got %0d expected %0d", boff, arise); end
    checks++; if (count !== 1)               begin failures++; $display("FAIL single_count: got %0d expected 1", count); end
    checks++; if (empty !== 1'b0)            begin failures++; $display("FAIL single_empty: got %b expected 0", empty); end
    checks++; if (dout !== 8'hA5)            begin failures++; $display("FAIL single_dout: got %h expected a5", dout); end
  endtask

  task automatic test_fifo_order();
    drain();
    for (int v = 1; v <= 5; v++) send_byte(8'(v));
    checks++; if (count !== 5) begin failures++; $display("FAIL order_count: got %0d expected 5", count); end
    pop = 1;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        checks++; if (dout !== 8'(i + 1)) begin failures++; $display("FAIL order_dout[%0d]: got %h expected %h", i, dout, 8'(i + 1)); end
        checks++; if (count !== 5 - i)    begin failures++; $display("FAIL order_level[%0d]: got %0d expected %0d", i, count, 5 - i); end
      end
      tick();
    end
    pop = 0;
    checks++; if (count !== 0 || empty !== 1'b1) begin failures++; $display("FAIL order_drained: count %0d empty %b expected 0 1", count, empty); end
  endtask

  task automatic test_overrun_full();
    drain();
    clr_ovr = 1; tick(); clr_ovr = 0;
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom_range(0, 255)));
    checks++; if (count !== DEPTH)   begin failures++; $display("FAIL full_count: got %0d expected %0d", count, DEPTH); end
    checks++; if (busy !== ~inv_busy || ack !== 1'b1) begin failures++; $display("FAIL full_wait_pins: busy %b ack %b expected %b 1", busy, ack, ~inv_busy); end
    checks++; if (overrun !== 1'b0)  begin failures++; $display("FAIL full_no_ovr: got %b expected 0", overrun); end
    send_byte(8'hEE);
    checks++; if (count !== DEPTH)   begin failures++; $display("FAIL ovr_count: got %0d expected %0d", count, DEPTH); end
    checks++; if (overrun !== 1'b1)  begin failures++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    checks++; if (dout !== exp_q[0]) begin failures++; $display("FAIL ovr_head: got %h expected %h", dout, exp_q[0]); end
    pop = 1; tick(); pop = 0;
    checks++; if (count !== DEPTH - 1) begin failures++; $display("FAIL pop_count: got %0d expected %0d", count, DEPTH - 1); end
    tick();
    checks++; if (busy !== inv_busy) begin failures++; $display("FAIL full_release: got %b expected %b", busy, inv_busy); end
    clr_ovr = 1; tick(); clr_ovr = 0;
    checks++; if (overrun !== 1'b0)  begin failures++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] x, last;
    send_byte(8'($urandom_range(0, 255)));
    checks++; if (count !== DEPTH) begin failures++; $display("FAIL fpp_prefill: got %0d expected %0d", count, DEPTH); end
    x = 8'($urandom_range(0, 255));
    drive_strobe(1'b1, 1'b0, x);
    tick(); tick();
    drive_strobe(1'b0, 1'b0, x);
    pop = 1; tick(); pop = 0;
    checks++; if (count !== DEPTH)  begin failures++; $display("FAIL fpp_count: got %0d expected %0d", count, DEPTH); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL fpp_overrun: got %b expected 0", overrun); end
    last = 8'h00;
    pop = 1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (dout !== exp_q[0]) begin failures++; $display("FAIL fpp_drain[%0d]: got %h expected %h", i, dout, exp_q[0]); end
      last = dout;
      tick();
    end
    pop = 0;
    checks++; if (last !== x)       begin failures++; $display("FAIL fpp_tail: got %h expected %h", last, x); end
    checks++; if (count !== 0)      begin failures++; $display("FAIL fpp_empty: got %0d expected 0", count); end
    repeat (4) tick();
  endtask

  task automatic test_inverted();
    inv_busy = 1;
    drive_strobe(1'b1, 1'b1, 8'h00);
    tick(); tick();
    checks++; if (busy !== 1'b1 || count !== 0) begin failures++; $display("FAIL inv_idle: busy %b count %0d expected 1 0", busy, count); end
    drive_strobe(1'b0, 1'b1, 8'h3C);
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL inv_busy_assert: got %b expected 0", busy); end
    drive_strobe(1'b1, 1'b1, 8'h3C);
    repeat (13) tick();
    checks++; if (busy !== 1'b1 || ack !== 1'b1) begin failures++; $display("FAIL inv_done: busy %b ack %b expected 1 1", busy, ack); end
    checks++; if (count !== 1 || dout !== 8'h3C) begin failures++; $display("FAIL inv_capture: count %0d dout %h expected 1 3c", count, dout); end
    drain();
    drive_strobe(1'b0, 1'b0, 8'h00);
    inv_busy = 0;
    tick();
  endtask

  task automatic test_random();
    int pct;
    for (int i = 0; i < 1400; i++) begin
      pct = (i < 700) ? 8 : 45;
      if ($urandom_range(0, 3) == 0) drive_strobe(~strobe, 1'b0, 8'($urandom_range(0, 255)));
      pop = ($urandom_range(0, 99) < pct);
      clr_ovr = ($urandom_range(0, 19) == 0);
      tick();
      checks++; if (count !== exp_q.size())      begin failures++; $display("FAIL rnd_count cyc %0d: got %0d expected %0d", cyc, count, exp_q.size()); end
      checks++; if (empty !== (exp_q.size() == 0)) begin failures++; $display("FAIL rnd_empty cyc %0d: got %b", cyc, empty); end
      checks++; if (overrun !== m_ov)            begin failures++; $display("FAIL rnd_overrun cyc %0d: got %b expected %b", cyc, overrun, m_ov); end
      checks++; if (busy !== (m_busy() ^ inv_busy)) begin failures++; $display("FAIL rnd_busy cyc %0d: got %b expected %b", cyc, busy, m_busy()); end
      checks++; if (ack !== m_ack())             begin failures++; $display("FAIL rnd_ack cyc %0d: got %b expected %b", cyc, ack, m_ack()); end
      if (exp_q.size() > 0) begin
        checks++; if (dout !== exp_q[0]) begin failures++; $display("FAIL rnd_dout cyc %0d: got %h expected %h", cyc, dout, exp_q[0]); end
      end
    end
    pop = 0; clr_ovr = 0;
    drive_strobe(1'b0, 1'b0, 8'h00);
    repeat (20) tick();
  endtask

  task automatic test_reset_mid();
    drain();
    repeat (20) tick();
    send_byte(8'h11);
    send_byte(8'h22);
    drive_strobe(1'b1, 1'b0, 8'h33);
    tick(); tick();
    drive_strobe(1'b0, 1'b0, 8'h33);
    repeat (3) tick();
    checks++; if (count !== 3 || busy !== 1'b1 || ack !== 1'b1) begin failures++; $display("FAIL mid_pre: count %0d busy %b ack %b expected 3 1 1", count, busy, ack); end
    rst = 0;
    #1;
    checks++; if (count !== 0 || empty !== 1'b1) begin failures++; $display("FAIL mid_fifo: count %0d empty %b expected 0 1", count, empty); end
    checks++; if (ack !== 1'b1 || busy !== inv_busy) begin failures++; $display("FAIL mid_hs: ack %b busy %b expected 1 %b", ack, busy, inv_busy); end
    checks++; if (overrun !== 1'b0 || dout !== 8'h00) begin failures++; $display("FAIL mid_regs: overrun %b dout %h expected 0 00", overrun, dout); end
    model_reset();
    tick(); tick();
    rst = 1;
    repeat (4) tick();
    checks++; if (count !== 0 || busy !== 1'b0) begin failures++; $display("FAIL mid_after: count %0d busy %b expected 0 0", count, busy); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_strobe();
    test_fifo_order();
    test_overrun_full();
    test_full_push_pop();
    test_inverted();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
